// File: rtl/operand_fetch_sequencer.sv
// Walks the PC through the operand or MVN/MVP bank bytes after an opcode. It then hands the packed
// operand, the advanced PC and the follow-on controller state to the execute side.
package cpu_pkg;
  typedef enum logic [4:0] {
    S_FETCH_OPCODE,
    S_FETCH_OPRAND_L,
    S_FETCH_BANK_1,
    S_ADDR_CALC,
    S_MOVE_READ,
    S_PUSH_H,
    S_PUSH_L,
    S_EXECUTE,
    S_WRITE_BACK
  } state_type;
endpackage

module operand_fetch_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  state_type   first_state,
  input  logic [1:0]  opr_len,
  input  logic [15:0] pc_in,
  input  logic [7:0]  pb_in,
  output logic        bus_req,
  output logic [23:0] bus_addr,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic        busy,
  output logic        done,
  output logic [23:0] operand,
  output logic [7:0]  dst_bank,
  output logic [7:0]  src_bank,
  output logic [15:0] pc_out,
  output state_type   next_state
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_L,
    FETCH_H,
    FETCH_B,
    BANK_1,
    BANK_2,
    DONE
  } seq_state_t;

  seq_state_t  state_reg;
  logic [15:0] pc_reg;
  logic [7:0]  pb_reg;
  logic [1:0]  len_reg;
  logic [15:0] pc_inc;
  logic        last_byte;

  // PB is deliberately left out of the increment: operand fetch wraps inside the bank.
  assign pc_inc = pc_reg + 16'd1;

  always_comb begin
    last_byte = 1'b0;
    case (state_reg)
      FETCH_L: last_byte = (len_reg < 2'd2);
      FETCH_H: last_byte = (len_reg != 2'd3);
      FETCH_B: last_byte = 1'b1;
      BANK_2:  last_byte = 1'b1;
      default: last_byte = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      pc_reg     <= 16'd0;
      pb_reg     <= 8'd0;
      len_reg    <= 2'd1;
      bus_req    <= 1'b0;
      bus_addr   <= 24'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      operand    <= 24'd0;
      dst_bank   <= 8'd0;
      src_bank   <= 8'd0;
      pc_out     <= 16'd0;
      next_state <= S_FETCH_OPCODE;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            pc_reg  <= pc_in;
            pb_reg  <= pb_in;
            len_reg <= (opr_len == 2'd0) ? 2'd1 : opr_len;
            busy    <= 1'b1;
            if (first_state == S_FETCH_OPRAND_L || first_state == S_FETCH_BANK_1) begin
              state_reg <= (first_state == S_FETCH_OPRAND_L) ? FETCH_L : BANK_1;
              if (first_state == S_FETCH_OPRAND_L) begin
                operand <= 24'd0;
              end
              bus_req  <= 1'b1;
              bus_addr <= {pb_in, pc_in};
            end else begin
              state_reg  <= DONE;
              done       <= 1'b1;
              pc_out     <= pc_in;
              next_state <= first_state;
            end
          end
        end

        FETCH_L, FETCH_H, FETCH_B, BANK_1, BANK_2: begin
          if (bus_ack) begin
            pc_reg   <= pc_inc;
            bus_addr <= {pb_reg, pc_inc};
            case (state_reg)
              FETCH_L: operand[7:0]   <= bus_rdata;
              FETCH_H: operand[15:8]  <= bus_rdata;
              FETCH_B: operand[23:16] <= bus_rdata;
              BANK_1:  dst_bank       <= bus_rdata;
              default: src_bank       <= bus_rdata;
            endcase
            if (last_byte) begin
              state_reg  <= DONE;
              bus_req    <= 1'b0;
              done       <= 1'b1;
              pc_out     <= pc_inc;
              next_state <= (state_reg == BANK_2) ? S_MOVE_READ : S_ADDR_CALC;
            end else begin
              case (state_reg)
                FETCH_L: state_reg <= FETCH_H;
                FETCH_H: state_reg <= FETCH_B;
                default: state_reg <= BANK_2;
              endcase
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          bus_req   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Bench for operand_fetch_sequencer: directed vector table, reset/stray-start sequences,
// and randomized transactions checked against a byte-count level reference model.
module tb_operand_fetch_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  state_type   first_state;
  logic [1:0]  opr_len;
  logic [15:0] pc_in;
  logic [7:0]  pb_in;
  logic        bus_req;
  logic [23:0] bus_addr;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic        busy;
  logic        done;
  logic [23:0] operand;
  logic [7:0]  dst_bank;
  logic [7:0]  src_bank;
  logic [15:0] pc_out;
  state_type   next_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  operand_fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .first_state(first_state),
    .opr_len(opr_len), .pc_in(pc_in), .pb_in(pb_in),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy), .done(done), .operand(operand), .dst_bank(dst_bank), .src_bank(src_bank),
    .pc_out(pc_out), .next_state(next_state)
  );

  typedef struct {
    state_type   fs;
    logic [1:0]  len;
    logic [15:0] pc;
    logic [7:0]  pb;
    logic [23:0] data;
    int          waits;
    logic [23:0] exp_operand;
    logic [7:0]  exp_dst;
    logic [7:0]  exp_src;
    logic [15:0] exp_pc;
    state_type   exp_next;
    int          exp_done;
    int          exp_req;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_operand"}, 32'(operand), 32'd0);
    chk({tag, "_dst_bank"}, 32'(dst_bank), 32'd0);
    chk({tag, "_src_bank"}, 32'(src_bank), 32'd0);
    chk({tag, "_pc_out"}, 32'(pc_out), 32'd0);
    chk({tag, "_next_state"}, 32'(next_state), 32'(S_FETCH_OPCODE));
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the IDLE return.
  task automatic run_txn(input state_type fs, input logic [1:0] len, input logic [15:0] pc,
                         input logic [7:0] pb, input logic [23:0] data,
                         input int w0, input int w1, input int w2, input bit stray,
                         output int done_cyc, output int req_cyc);
    int wt[3];
    int idx;
    int c;
    logic [23:0] exp_addr;
    wt = '{w0, w1, w2};
    idx = 0;
    c = 0;
    done_cyc = -1;
    req_cyc = 0;
    start = 1'b1;
    first_state = fs;
    opr_len = len;
    pc_in = pc;
    pb_in = pb;
    bus_ack = 1'b0;
    while (done_cyc < 0 && c < 100) begin
      @(negedge clk);
      c++;
      start = stray && (c == 1);
      if (start) begin
        first_state = S_PUSH_H;
        pc_in = 16'($urandom);
      end
      bus_ack = 1'b0;
      if (c == 1) chk("busy_cycle1", 32'(busy), 32'd1);
      if (bus_req) begin
        exp_addr = {pb, pc + 16'(idx)};
        chk("bus_addr", 32'(bus_addr), 32'(exp_addr));
        req_cyc++;
        if (idx < 3 && wt[idx] > 0) begin
          wt[idx]--;
        end else begin
          bus_ack = 1'b1;
          bus_rdata = (idx < 3) ? data[8*idx +: 8] : 8'h00;
          idx++;
        end
      end
      if (done) done_cyc = c;
    end
    start = 1'b0;
    bus_ack = 1'b0;
    if (done_cyc < 0) $display("FAIL done_timeout: got no done expected done within 100 cycles");
    @(negedge clk);
  endtask

  task automatic check_txn(input string tag, input state_type fs, input int done_cyc,
                           input int req_cyc, input logic [23:0] exp_op, input logic [7:0] exp_dst,
                           input logic [7:0] exp_src, input logic [15:0] exp_pc,
                           input state_type exp_next, input int exp_done, input int exp_req);
    chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("req_cycles", 32'(req_cyc), 32'(exp_req));
    chk("pc_out", 32'(pc_out), 32'(exp_pc));
    chk("next_state", 32'(next_state), 32'(exp_next));
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd0);
    if (fs == S_FETCH_OPRAND_L) chk("operand", 32'(operand), 32'(exp_op));
    if (fs == S_FETCH_BANK_1) begin
      chk("dst_bank", 32'(dst_bank), 32'(exp_dst));
      chk("src_bank", 32'(src_bank), 32'(exp_src));
    end
    $display("%s fs=%s done@%0d req=%0d pc_out=%h op=%h dst=%h src=%h next=%s",
             tag, fs.name(), done_cyc, req_cyc, pc_out, operand, dst_bank, src_bank,
             next_state.name());
  endtask

  vec_t tbl[6];
  state_type fs_pool[4];

  initial begin
    int dc;
    int rc;
    tbl[0] = '{S_FETCH_OPRAND_L, 2'd3, 16'h3456, 8'h12, 24'hCCBBAA, 0,
               24'hCCBBAA, 8'h00, 8'h00, 16'h3459, S_ADDR_CALC, 4, 3};
    tbl[1] = '{S_FETCH_OPRAND_L, 2'd2, 16'hFFFF, 8'h01, 24'h332211, 0,
               24'h002211, 8'h00, 8'h00, 16'h0001, S_ADDR_CALC, 3, 2};
    tbl[2] = '{S_FETCH_OPRAND_L, 2'd1, 16'h1000, 8'h05, 24'h00005A, 3,
               24'h00005A, 8'h00, 8'h00, 16'h1001, S_ADDR_CALC, 5, 4};
    tbl[3] = '{S_FETCH_OPRAND_L, 2'd0, 16'h2000, 8'h05, 24'hFFFFA5, 0,
               24'h0000A5, 8'h00, 8'h00, 16'h2001, S_ADDR_CALC, 2, 1};
    tbl[4] = '{S_FETCH_BANK_1, 2'd1, 16'h4000, 8'h00, 24'h007F7E, 0,
               24'h000000, 8'h7E, 8'h7F, 16'h4002, S_MOVE_READ, 3, 2};
    tbl[5] = '{S_PUSH_H, 2'd3, 16'h1234, 8'h33, 24'h000000, 0,
               24'h000000, 8'h00, 8'h00, 16'h1234, S_PUSH_H, 1, 0};
    fs_pool = '{S_FETCH_OPRAND_L, S_FETCH_BANK_1, S_PUSH_H, S_EXECUTE};

    reset = 1'b1;
    start = 1'b0;
    first_state = S_FETCH_OPCODE;
    opr_len = 2'd0;
    pc_in = 16'd0;
    pb_in = 8'd0;
    bus_rdata = 8'd0;
    bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_init");
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_txn(tbl[i].fs, tbl[i].len, tbl[i].pc, tbl[i].pb, tbl[i].data,
              tbl[i].waits, 0, 0, (i % 2) == 1, dc, rc);
      check_txn($sformatf("vec%0d", i), tbl[i].fs, dc, rc, tbl[i].exp_operand, tbl[i].exp_dst,
                tbl[i].exp_src, tbl[i].exp_pc, tbl[i].exp_next, tbl[i].exp_done, tbl[i].exp_req);
    end

    // Reset while stalled on the second operand byte.
    start = 1'b1;
    first_state = S_FETCH_OPRAND_L;
    opr_len = 2'd3;
    pc_in = 16'h1111;
    pb_in = 8'h22;
    @(negedge clk);
    start = 1'b0;
    chk("rst_seq_req1", 32'(bus_req), 32'd1);
    bus_ack = 1'b1;
    bus_rdata = 8'h99;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("rst_seq_addr2", 32'(bus_addr), 32'h221112);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_mid");
    $display("reset_mid bus_req=%b busy=%b operand=%h", bus_req, busy, operand);
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      state_type fs;
      logic [1:0] len;
      logic [15:0] pc;
      logic [7:0] pb;
      logic [23:0] data;
      logic [23:0] exp_op;
      int w[3];
      int n;
      int wsum;
      state_type exp_next;
      fs = fs_pool[$urandom_range(0, 3)];
      len = 2'($urandom);
      pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
      pb = 8'($urandom);
      data = 24'($urandom);
      for (int k = 0; k < 3; k++) w[k] = $urandom_range(0, 2);
      n = (fs == S_FETCH_OPRAND_L) ? ((len == 2'd0) ? 1 : int'(len)) :
          (fs == S_FETCH_BANK_1) ? 2 : 0;
      wsum = 0;
      exp_op = 24'd0;
      for (int k = 0; k < n; k++) begin
        wsum += w[k];
        exp_op[8*k +: 8] = data[8*k +: 8];
      end
      exp_next = (fs == S_FETCH_OPRAND_L) ? S_ADDR_CALC :
                 (fs == S_FETCH_BANK_1) ? S_MOVE_READ : fs;
      run_txn(fs, len, pc, pb, data, w[0], w[1], w[2], $urandom_range(0, 1) == 1, dc, rc);
      check_txn($sformatf("rnd%0d", t), fs, dc, rc, exp_op, data[7:0], data[15:8],
                pc + 16'(n), exp_next, 1 + n + wsum, n + wsum);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
